// File: rtl/masked_sbox_arbiter.sv
// Arbitrates state and key-schedule bytes onto one masked GF(2^8) inverse pipeline,
// tags each issued byte, steers the result back to its owner and gates the PRNG.
module masked_sbox_arbiter #(
  parameter int NUM_SHARES = 2,
  parameter int LATENCY    = 4
) (
  input  logic                        in_clock,
  input  logic                        in_reset,
  input  logic                        in_st_valid,
  input  logic [3:0]                  in_st_idx,
  input  logic [NUM_SHARES-1:0][7:0]  in_st_data,
  output logic                        out_st_ready,
  input  logic                        in_ks_valid,
  input  logic [1:0]                  in_ks_idx,
  input  logic [NUM_SHARES-1:0][7:0]  in_ks_data,
  output logic                        out_ks_ready,
  output logic [NUM_SHARES-1:0][7:0]  out_inv_in,
  output logic                        out_rand_step,
  input  logic [NUM_SHARES-1:0][7:0]  in_inv_out,
  output logic                        out_st_res_valid,
  output logic [3:0]                  out_st_res_idx,
  output logic                        out_ks_res_valid,
  output logic [1:0]                  out_ks_res_idx,
  output logic [NUM_SHARES-1:0][7:0]  out_res_data,
  output logic                        out_idle
);

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_KS = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic [3:0] idx;
  } tag_t;

  owner_e rr_last;
  tag_t   tag_q [LATENCY];
  tag_t   tag_in;
  tag_t   tag_out;
  logic   gnt_st;
  logic   gnt_ks;
  logic   in_flight;

  // Grant depends only on request valids and the registered rr_last.
  always_comb begin
    gnt_st = 1'b0;
    gnt_ks = 1'b0;
    if (!in_reset) begin
      unique case ({in_st_valid, in_ks_valid})
        2'b11: begin
          gnt_st = (rr_last == OWN_KS);
          gnt_ks = (rr_last == OWN_ST);
        end
        2'b10:   gnt_st = 1'b1;
        2'b01:   gnt_ks = 1'b1;
        default: ;
      endcase
    end
  end

  assign out_st_ready = gnt_st;
  assign out_ks_ready = gnt_ks;

  // One-hot select; zero shares when idle so requesters never mix.
  always_comb begin
    out_inv_in = '0;
    tag_in     = '0;
    unique case (1'b1)
      gnt_st: begin
        out_inv_in   = in_st_data;
        tag_in.valid = 1'b1;
        tag_in.owner = OWN_ST;
        tag_in.idx   = in_st_idx;
      end
      gnt_ks: begin
        out_inv_in   = in_ks_data;
        tag_in.valid = 1'b1;
        tag_in.owner = OWN_KS;
        tag_in.idx   = {2'b00, in_ks_idx};
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      rr_last <= OWN_KS;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (gnt_st) begin
        rr_last <= OWN_ST;
      end else if (gnt_ks) begin
        rr_last <= OWN_KS;
      end
    end
  end

  // The last tag stage marks the output cycle, which draws no randomness.
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      in_flight = in_flight | tag_q[i].valid;
    end
  end

  assign tag_out = tag_q[LATENCY-1];

  assign out_st_res_valid = tag_out.valid && (tag_out.owner == OWN_ST);
  assign out_ks_res_valid = tag_out.valid && (tag_out.owner == OWN_KS);
  assign out_st_res_idx   = tag_out.idx;
  assign out_ks_res_idx   = tag_out.idx[1:0];
  assign out_res_data     = in_inv_out;

  assign out_rand_step = gnt_st | gnt_ks | in_flight;
  assign out_idle      = !in_flight && !in_st_valid && !in_ks_valid;

endmodule

// File: tb/tb_masked_sbox_arbiter.sv
// Directed bench for masked_sbox_arbiter with a behavioural masked inverse
// pipeline and an in-order scoreboard on every returned byte.
module tb_masked_sbox_arbiter;

  localparam int NS  = 2;
  localparam int LAT = 4;

  typedef logic [NS-1:0][7:0] sh_t;

  typedef struct {
    logic [3:0] idx;
    sh_t        d;
  } byte_t;

  typedef struct {
    logic       own;
    logic [3:0] idx;
    logic [7:0] val;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st_valid = 1'b0;
  logic [3:0] st_idx = '0;
  sh_t        st_data = '0;
  logic       st_ready;
  logic       ks_valid = 1'b0;
  logic [1:0] ks_idx = '0;
  sh_t        ks_data = '0;
  logic       ks_ready;
  sh_t        inv_in;
  logic       rand_step;
  sh_t        inv_out;
  logic       st_res_valid;
  logic [3:0] st_res_idx;
  logic       ks_res_valid;
  logic [1:0] ks_res_idx;
  sh_t        res_data;
  logic       idle;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  masked_sbox_arbiter #(.NUM_SHARES(NS), .LATENCY(LAT)) dut (
    .in_clock         (clk),
    .in_reset         (rst),
    .in_st_valid      (st_valid),
    .in_st_idx        (st_idx),
    .in_st_data       (st_data),
    .out_st_ready     (st_ready),
    .in_ks_valid      (ks_valid),
    .in_ks_idx        (ks_idx),
    .in_ks_data       (ks_data),
    .out_ks_ready     (ks_ready),
    .out_inv_in       (inv_in),
    .out_rand_step    (rand_step),
    .in_inv_out       (inv_out),
    .out_st_res_valid (st_res_valid),
    .out_st_res_idx   (st_res_idx),
    .out_ks_res_valid (ks_res_valid),
    .out_ks_res_idx   (ks_res_idx),
    .out_res_data     (res_data),
    .out_idle         (idle)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] unmask(input sh_t s);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < NS; i++) v = v ^ s[i];
    return v;
  endfunction

  function automatic sh_t reshare(input logic [7:0] v);
    sh_t s;
    logic [7:0] acc = v;
    for (int i = 0; i < NS - 1; i++) begin
      s[i] = 8'($urandom);
      acc  = acc ^ s[i];
    end
    s[NS-1] = acc;
    return s;
  endfunction

  function automatic byte_t mk(input int idx, input logic [7:0] val);
    byte_t b;
    b.idx = 4'(idx);
    b.d   = reshare(val);
    return b;
  endfunction

  // Behavioural masked inverse pipeline, re-masked on entry.
  sh_t pipe [LAT];
  assign inv_out = pipe[LAT-1];
  always @(posedge clk) begin
    pipe[0] <= reshare(gf_inv(unmask(inv_in)));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  exp_t       sb [$];
  exp_t       e;
  int         iss_cyc [$];
  logic       iss_own [$];
  int         res_cyc [$];
  logic       res_own [$];
  logic [3:0] res_idx [$];
  logic [7:0] res_val [$];
  logic       rs_log   [64];
  logic       idle_log [64];

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (cyc < 64) begin
        rs_log[cyc]   = rand_step;
        idle_log[cyc] = idle;
      end
      check("ready_excl", 32'(st_ready & ks_ready), 0);
      if (st_ready) begin
        check("inv_in_st", 32'(inv_in), 32'(st_data));
        sb.push_back('{1'b0, st_idx, gf_inv(unmask(st_data)), cyc});
        iss_own.push_back(1'b0);
        iss_cyc.push_back(cyc);
      end else if (ks_ready) begin
        check("inv_in_ks", 32'(inv_in), 32'(ks_data));
        sb.push_back('{1'b1, {2'b00, ks_idx}, gf_inv(unmask(ks_data)), cyc});
        iss_own.push_back(1'b1);
        iss_cyc.push_back(cyc);
      end else begin
        check("inv_in_zero", 32'(inv_in), 0);
      end
      if (st_res_valid || ks_res_valid) begin
        check("res_excl", 32'(st_res_valid & ks_res_valid), 0);
        res_cyc.push_back(cyc);
        res_own.push_back(ks_res_valid);
        res_idx.push_back(ks_res_valid ? {2'b00, ks_res_idx} : st_res_idx);
        res_val.push_back(unmask(res_data));
        if (sb.size() == 0) begin
          check("spurious_res", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_owner", 32'(ks_res_valid), 32'(e.own));
          check("res_idx", 32'(ks_res_valid ? {2'b00, ks_res_idx} : st_res_idx),
                32'(e.idx));
          check("res_data", 32'(unmask(res_data)), 32'(e.val));
          check("res_latency", cyc - e.c, LAT);
        end
      end
    end
  end

  byte_t st_q [$];
  byte_t ks_q [$];

  task automatic clear_logs();
    iss_cyc.delete();
    iss_own.delete();
    res_cyc.delete();
    res_own.delete();
    res_idx.delete();
    res_val.delete();
    for (int i = 0; i < 64; i++) begin
      rs_log[i]   = 1'bx;
      idle_log[i] = 1'bx;
    end
  endtask

  task automatic reset_dut();
    st_valid = 1'b0;
    ks_valid = 1'b0;
    st_q.delete();
    ks_q.delete();
    rst = 1'b1;
    #1;
    check("rst_st_res", 32'(st_res_valid), 0);
    check("rst_ks_res", 32'(ks_res_valid), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_rand", 32'(rand_step), 0);
    check("rst_inv_in", 32'(inv_in), 0);
    st_valid = 1'b1;
    ks_valid = 1'b1;
    #1;
    check("rst_ready", 32'({st_ready, ks_ready}), 0);
    check("rst_inv_in_req", 32'(inv_in), 0);
    st_valid = 1'b0;
    ks_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    clear_logs();
  endtask

  task automatic drive_cycle();
    logic sa;
    logic ka;
    st_valid = (st_q.size() != 0);
    ks_valid = (ks_q.size() != 0);
    st_idx   = st_valid ? st_q[0].idx : 4'h0;
    st_data  = st_valid ? st_q[0].d : '0;
    ks_idx   = ks_valid ? ks_q[0].idx[1:0] : 2'h0;
    ks_data  = ks_valid ? ks_q[0].d : '0;
    #2;
    sa = st_ready;
    ka = ks_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (sa) void'(st_q.pop_front());
    if (ka) void'(ks_q.pop_front());
  endtask

  task automatic run(input int max_cyc);
    int n = 0;
    while ((st_q.size() != 0 || ks_q.size() != 0) && n < max_cyc) begin
      drive_cycle();
      n++;
    end
    st_valid = 1'b0;
    ks_valid = 1'b0;
    check("drain_budget", st_q.size() + ks_q.size(), 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) drive_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: state burst, in-order results LAT cycles later
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      st_q.push_back(mk(i, i == 0 ? 8'h00 : (i == 1 ? 8'h53 : 8'($urandom))));
    end
    run(40);
    wait_cycles(LAT + 4);
    check("s1_issues", iss_cyc.size(), 16);
    check("s1_res_count", res_cyc.size(), 16);
    for (int i = 0; i < 16 && i < res_cyc.size(); i++) begin
      check("s1_res_cyc", res_cyc[i], LAT + i);
      check("s1_res_idx", 32'(res_idx[i]), i);
      check("s1_res_own", 32'(res_own[i]), 0);
    end
    if (res_val.size() >= 2) begin
      check("s1_inv_00", 32'(res_val[0]), 32'h00);
      check("s1_inv_53", 32'(res_val[1]), 32'hCA);
    end
    check("s1_sb_empty", sb.size(), 0);

    // 2: contested, strict alternation until key bytes run out
    reset_dut();
    for (int i = 0; i < 16; i++) st_q.push_back(mk(i, 8'($urandom)));
    for (int i = 0; i < 4; i++) ks_q.push_back(mk(i, 8'($urandom)));
    run(40);
    check("s2_issues", iss_cyc.size(), 20);
    if (iss_cyc.size() == 20) check("s2_last_issue", iss_cyc[19], 19);
    for (int i = 0; i < 20 && i < iss_own.size(); i++) begin
      check("s2_grant_own", 32'(iss_own[i]), (i < 8) ? (i % 2) : 0);
    end
    wait_cycles(LAT + 4);
    check("s2_res_count", res_cyc.size(), 20);
    check("s2_sb_empty", sb.size(), 0);

    // 3: lone key byte, PRNG gating and idle
    reset_dut();
    wait_cycles(5);
    ks_q.push_back(mk(3, 8'h01));
    run(5);
    wait_cycles(8);
    check("s3_res_count", res_cyc.size(), 1);
    if (res_cyc.size() == 1) begin
      check("s3_res_cyc", res_cyc[0], 5 + LAT);
      check("s3_res_own", 32'(res_own[0]), 1);
      check("s3_res_idx", 32'(res_idx[0]), 3);
      check("s3_res_val", 32'(res_val[0]), 32'h01);
    end
    for (int c = 0; c < 14; c++) begin
      check("s3_rand_step", 32'(rs_log[c]), 32'(c >= 5 && c < 5 + LAT));
      check("s3_idle", 32'(idle_log[c]), 32'(!(c >= 5 && c < 5 + LAT)));
    end

    // 4: async reset with bytes in flight
    reset_dut();
    for (int i = 0; i < 3; i++) st_q.push_back(mk(i, 8'($urandom)));
    run(10);
    #1;
    check("s4_busy", 32'(idle), 0);
    rst = 1'b1;
    #1;
    check("s4_rst_st_res", 32'(st_res_valid), 0);
    check("s4_rst_ks_res", 32'(ks_res_valid), 0);
    check("s4_rst_idle", 32'(idle), 1);
    check("s4_rst_rand", 32'(rand_step), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    clear_logs();
    st_q.push_back(mk(9, 8'($urandom)));
    ks_q.push_back(mk(1, 8'($urandom)));
    run(10);
    wait_cycles(12);
    check("s4_issues", iss_own.size(), 2);
    if (iss_own.size() == 2) begin
      check("s4_first_own", 32'(iss_own[0]), 0);
      check("s4_second_own", 32'(iss_own[1]), 1);
      check("s4_second_cyc", iss_cyc[1], 1);
    end
    check("s4_res_count", res_cyc.size(), 2);
    if (res_cyc.size() == 2) begin
      check("s4_res0_cyc", res_cyc[0], LAT);
      check("s4_res0_idx", 32'(res_idx[0]), 9);
      check("s4_res1_cyc", res_cyc[1], LAT + 1);
      check("s4_res1_idx", 32'(res_idx[1]), 1);
      check("s4_res1_own", 32'(res_own[1]), 1);
    end

    // 5: random traffic against the scoreboard
    reset_dut();
    for (int n = 0; n < 10000; n++) begin
      if (st_q.size() == 0 && $urandom_range(0, 3) != 0) begin
        st_q.push_back(mk($urandom_range(0, 15), 8'($urandom)));
      end
      if (ks_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        ks_q.push_back(mk($urandom_range(0, 3), 8'($urandom)));
      end
      drive_cycle();
    end
    run(10);
    wait_cycles(LAT + 4);
    check("s5_sb_empty", sb.size(), 0);
    check("s5_res_vs_issue", res_cyc.size(), iss_cyc.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
